// File: rtl/iscas_bist_pkg.sv
// iscas_bist_pkg
// Shared types and constants for the ISCAS-85 stimulus/response engine and
// the harnesses built around it.
//   bist_mode_e  : pattern family selected on the mode input
//   bist_state_e : controller states
//   C432_*       : port widths and LFSR taps for the c432 benchmark
//   DEFAULT_MISR_POLY : default 16-bit MISR feedback polynomial
package iscas_bist_pkg;

    localparam int          C432_IN_W         = 36;
    localparam int          C432_OUT_W        = 7;
    localparam logic [35:0] C432_LFSR_POLY    = 36'h800000800;
    localparam logic [15:0] DEFAULT_MISR_POLY = 16'h1021;

    typedef enum logic [1:0] {
        MODE_WALK0 = 2'd0,
        MODE_WALK1 = 2'd1,
        MODE_COUNT = 2'd2,
        MODE_LFSR  = 2'd3
    } bist_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HOLD = 3'd1,
        ST_CAPT = 3'd2,
        ST_FIN  = 3'd3,
        ST_DONE = 3'd4
    } bist_state_e;

endpackage

// File: rtl/iscas_misr.sv
// iscas_misr
// Multiple-input signature register. Each enabled cycle shifts the signature
// left, folds in the feedback polynomial when the MSB falls out, and XORs in
// the zero-extended response word.
// Ports:
//   clk      : clock
//   rst      : asynchronous active-high reset, clears the signature
//   clear_i  : synchronous clear (wins over enable)
//   enable_i : compress data_i into the signature this cycle
//   data_i   : OUT_W-bit response word
//   sig_o    : current signature
module iscas_misr
    import iscas_bist_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter int               OUT_W = C432_OUT_W,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEFAULT_MISR_POLY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [OUT_W-1:0] data_i,
    output logic [SIG_W-1:0] sig_o
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clear_i) begin
            sig_d = '0;
        end else if (enable_i) begin
            sig_d = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? POLY : '0)
                  ^ SIG_W'(data_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/iscas_bist_ctrl.sv
// iscas_bist_ctrl
// Stimulus and response engine for a combinational ISCAS-85 benchmark.
// Applies a walking-zero, walking-one, counting or Galois-LFSR pattern
// sequence, holds each pattern for a settle window, compresses the DUT
// response into a MISR and compares the final signature against a golden
// value latched at start.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   start, abort  : host handshake; abort wins over start
//   mode          : pattern family (bist_mode_e), sampled with start
//   golden_sig    : expected signature, sampled with start
//   dut_in        : pattern driven to the DUT
//   dut_out       : DUT response
//   busy, done    : run in progress / run complete (level)
//   pass          : signature matched golden, valid while done
//   signature     : running/final MISR value
//   pat_idx       : index of the pattern currently applied
module iscas_bist_ctrl
    import iscas_bist_pkg::*;
#(
    parameter int               IN_W      = C432_IN_W,
    parameter int               OUT_W     = C432_OUT_W,
    parameter int               SIG_W     = 16,
    parameter logic [SIG_W-1:0] MISR_POLY = SIG_W'(DEFAULT_MISR_POLY),
    parameter logic [IN_W-1:0]  LFSR_POLY = IN_W'(C432_LFSR_POLY),
    parameter logic [IN_W-1:0]  LFSR_SEED = IN_W'(1),
    parameter int               NUM_PAT   = 256,
    parameter int               SETTLE    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic [SIG_W-1:0] golden_sig,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature,
    output logic [15:0]      pat_idx
);

    // An all-zero seed would lock the LFSR at zero forever.
    localparam logic [IN_W-1:0] SEED_EFF  = (LFSR_SEED == '0) ? IN_W'(1) : LFSR_SEED;
    localparam logic [3:0]      SETTLE_C  = 4'(SETTLE);
    localparam logic [15:0]     LAST_WALK = 16'(IN_W - 1);
    localparam logic [15:0]     LAST_NUM  = 16'(NUM_PAT - 1);

    bist_state_e      state_q, state_d;
    bist_mode_e       mode_q, mode_d;
    logic [SIG_W-1:0] golden_q, golden_d;
    logic [IN_W-1:0]  dutIn_q, dutIn_d;
    logic [15:0]      patIdx_q, patIdx_d;
    logic [3:0]       holdCnt_q, holdCnt_d;
    logic             pass_q, pass_d;
    logic             misrClear, misrEn;
    logic [SIG_W-1:0] misrSig;
    logic [15:0]      lastIdx;

    // Pattern for index idx. The LFSR family is sequential, so it steps the
    // currently applied pattern instead of using the index.
    function automatic logic [IN_W-1:0] nextPattern(input bist_mode_e m,
                                                    input logic [15:0] idx,
                                                    input logic [IN_W-1:0] cur);
        logic [IN_W-1:0] oneHot;
        oneHot = IN_W'(1) << idx;
        case (m)
            MODE_WALK0: return ~oneHot;
            MODE_WALK1: return oneHot;
            MODE_COUNT: return IN_W'(idx);
            default:    return {cur[IN_W-2:0], 1'b0} ^ (cur[IN_W-1] ? LFSR_POLY : '0);
        endcase
    endfunction

    function automatic logic [IN_W-1:0] firstPattern(input bist_mode_e m);
        return (m == MODE_LFSR) ? SEED_EFF : nextPattern(m, 16'd0, '0);
    endfunction

    assign lastIdx = (mode_q == MODE_WALK0 || mode_q == MODE_WALK1) ? LAST_WALK : LAST_NUM;

    // Next-state logic. The first HOLD after start counts from 0 so the
    // opening pattern gets one extra cycle to settle after leaving IDLE/DONE;
    // later HOLDs count from 1 and last exactly SETTLE cycles.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        golden_d  = golden_q;
        dutIn_d   = dutIn_q;
        patIdx_d  = patIdx_q;
        holdCnt_d = holdCnt_q;
        pass_d    = pass_q;
        misrClear = 1'b0;
        misrEn    = 1'b0;
        if (abort) begin
            if (state_q != ST_IDLE) begin
                state_d = ST_IDLE;
                pass_d  = 1'b0;
                dutIn_d = '0;
            end
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        mode_d    = bist_mode_e'(mode);
                        golden_d  = golden_sig;
                        patIdx_d  = '0;
                        holdCnt_d = '0;
                        pass_d    = 1'b0;
                        dutIn_d   = firstPattern(bist_mode_e'(mode));
                        misrClear = 1'b1;
                        state_d   = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (holdCnt_q == SETTLE_C) begin
                        state_d = ST_CAPT;
                    end else begin
                        holdCnt_d = holdCnt_q + 4'd1;
                    end
                end
                ST_CAPT: begin
                    misrEn = 1'b1;
                    if (patIdx_q == lastIdx) begin
                        state_d = ST_FIN;
                    end else begin
                        patIdx_d  = patIdx_q + 16'd1;
                        dutIn_d   = nextPattern(mode_q, patIdx_q + 16'd1, dutIn_q);
                        holdCnt_d = 4'd1;
                        state_d   = (SETTLE == 0) ? ST_CAPT : ST_HOLD;
                    end
                end
                ST_FIN: begin
                    pass_d  = (misrSig == golden_q);
                    state_d = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_WALK0;
            golden_q  <= '0;
            dutIn_q   <= '0;
            patIdx_q  <= '0;
            holdCnt_q <= '0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            golden_q  <= golden_d;
            dutIn_q   <= dutIn_d;
            patIdx_q  <= patIdx_d;
            holdCnt_q <= holdCnt_d;
            pass_q    <= pass_d;
        end
    end

    iscas_misr #(
        .SIG_W (SIG_W),
        .OUT_W (OUT_W),
        .POLY  (MISR_POLY)
    ) uMisr (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (misrClear),
        .enable_i (misrEn),
        .data_i   (dut_out),
        .sig_o    (misrSig)
    );

    assign dut_in    = dutIn_q;
    assign busy      = (state_q == ST_HOLD) || (state_q == ST_CAPT) || (state_q == ST_FIN);
    assign done      = (state_q == ST_DONE);
    assign pass      = pass_q;
    assign signature = misrSig;
    assign pat_idx   = patIdx_q;

endmodule

// File: doc/iscas_bist_ctrl.md
Name: iscas_bist_ctrl

Overview:
Parametrised, synthesisable stimulus and response engine for ISCAS-85 combinational benchmarks (c432 first, others by parameter).
- Drives DUT inputs with walking-zero, walking-one, counting or LFSR pattern sequences.
- Holds each pattern for a settle window and compresses DUT outputs into a MISR signature.
- Compares the final signature against a golden value and reports pass/fail.
- Sits between a start/done host handshake and the combinational DUT.

Parameters:
IN_W, 36, DUT input width (c432: 36)
OUT_W, 7, DUT output width (c432: 7)
SIG_W, 16, MISR width; must be >= OUT_W
MISR_POLY, 16'h1021, MISR feedback polynomial (SIG_W bits)
LFSR_POLY, 36'h800000800, Galois LFSR feedback taps (IN_W bits)
LFSR_SEED, 36'h1, LFSR seed; if zero, 1 is used
NUM_PAT, 256, pattern count for COUNT/LFSR modes (1..2^16-1)
SETTLE, 1, hold cycles before capture (0..15)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  launch a run; sampled only in IDLE/DONE
abort  in  1  cancel a run; returns to IDLE
mode  in  2  0 walk-zero, 1 walk-one, 2 count, 3 LFSR; sampled with start
golden_sig  in  SIG_W  expected signature; sampled with start
dut_in  out  IN_W  pattern applied to the DUT
dut_out  in  OUT_W  DUT response
busy  out  1  run in progress
done  out  1  run complete; level, held until next start/abort
pass  out  1  signature == golden; valid while done=1
signature  out  SIG_W  running/final MISR value
pat_idx  out  16  index of the pattern currently applied

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state IDLE; dut_in=0, busy=0, done=0, pass=0, signature=0, pat_idx=0. Reset mid-run aborts immediately with no partial result.
- States: IDLE -> HOLD -> CAPT -> (HOLD | FIN) -> DONE.
- IDLE/DONE with start=1:
  - Latch mode and golden_sig; clear signature and pat_idx.
  - Load pattern 0 into dut_in; go to HOLD; busy=1 and done=0 from the next cycle.
- HOLD: remains for SETTLE cycles; SETTLE=0 skips straight to CAPT.
- CAPT: one cycle; signature <= (sig<<1) ^ (sig[SIG_W-1] ? MISR_POLY : 0) ^ zero-extend(dut_out).
  - If pat_idx == P-1, go to FIN.
  - Otherwise pat_idx++, load the next pattern into dut_in, go to HOLD.
- Pattern count P: IN_W for walking modes, NUM_PAT otherwise.
- Each pattern occupies SETTLE+1 cycles. done rises SETTLE+1)*P+2 edges after the start edge.
- FIN: one cycle; pass <= (signature == golden_reg); go to DONE.
- DONE: busy=0, done=1; dut_in holds the last pattern; signature is frozen.
- Patterns for index i:
  - walk-zero: all ones with bit i = 0.
  - walk-one: only bit i = 1.
  - count: i zero-extended/truncated to IN_W.
  - LFSR: seed at i=0; Galois step per pattern: shift left, XOR LFSR_POLY if the MSB shifted out was 1.
- abort (any state except IDLE): next state IDLE, busy=0, done=0, pass=0, dut_in=0. abort has priority over start in the same cycle.
- start while busy is ignored.
- Mode 2 with IN_W < 16: the pattern wraps modulo 2^IN_W.

Decomposition:
- Package iscas_bist_pkg: mode enum, state enum, default MISR_POLY and c432 width constants.
- Sub-module iscas_misr: parametrised SIG_W/OUT_W MISR with clear and enable; reused by later benchmark harnesses.
- The pattern generator stays inline.

Test Plan:
- Reset mid-run: assert rst during HOLD -> all outputs 0 asynchronously; a start after release runs cleanly.
- Params IN_W=4, OUT_W=4, SIG_W=8, MISR_POLY=8'h1D, SETTLE=1, loopback dut_out=dut_in, mode 0, golden 8'h55.
  - dut_in = E, D, B, 7, each held 2 cycles.
  - signature = 0E, 11, 29, 55.
  - done exactly 10 edges after start; pass=1.
- Same params, mode 1, golden 8'h00 -> dut_in = 1, 2, 4, 8; final signature 00; pass=1.
- Same params, mode 2, NUM_PAT=4, golden 8'h04 -> signature 03; pass=0 with done=1.
- abort and start in the same cycle during HOLD -> IDLE, done=0, pass=0; a later start restarts at pat_idx=0.
- SETTLE=0, mode 0 -> one cycle per pattern; done 6 edges after start; same signature 55.
